// File: rtl/mavg_filter_mc_if.sv
// Sample-in / average-out bundle for mavg_filter_mc.
// The master side drives samples and control; the slave side (the filter) returns averages.
interface mavg_filter_mc_if #(
  parameter int N     = 16,
  parameter int M_MAX = 3,
  parameter int C     = 4
);
  localparam int CW = (C > 1) ? $clog2(C) : 1;
  localparam int WW = ($clog2(M_MAX + 1) > 0) ? $clog2(M_MAX + 1) : 1;

  logic [N-1:0]  sample;
  logic          sample_valid;
  logic [CW-1:0] sample_chan;
  logic [WW-1:0] win_log2;
  logic          clear;
  logic [N-1:0]  average;
  logic          average_valid;
  logic [CW-1:0] average_chan;
  logic [C-1:0]  warm;

  modport master (
    output sample, sample_valid, sample_chan, win_log2, clear,
    input  average, average_valid, average_chan, warm
  );

  modport slave (
    input  sample, sample_valid, sample_chan, win_log2, clear,
    output average, average_valid, average_chan, warm
  );
endinterface

// File: rtl/mavg_filter_mc.sv
// Multi-channel moving-average filter with runtime window 2**W, one sample per cycle.
// Optional macro MAVG_ROUND_EN selects round-half-up instead of truncation.
module mavg_filter_mc #(
  parameter int N     = 16,
  parameter int M_MAX = 3,
  parameter int C     = 4
) (
  input  logic             clk,
  input  logic             rst,
  mavg_filter_mc_if.slave  bus
);
  localparam int CW    = (C > 1) ? $clog2(C) : 1;
  localparam int WW    = ($clog2(M_MAX + 1) > 0) ? $clog2(M_MAX + 1) : 1;
  localparam int DEPTH = 2 ** M_MAX;
  localparam int SW    = N + M_MAX;
  localparam int FW    = M_MAX + 1;

  logic [N-1:0]       mem_q   [C][DEPTH];
  logic [M_MAX-1:0]   wptr_q  [C];
  logic [M_MAX-1:0]   wptr_d  [C];
  logic [FW-1:0]      fill_q  [C];
  logic [FW-1:0]      fill_d  [C];
  logic [SW-1:0]      sum_q   [C];
  logic [SW-1:0]      sum_d   [C];
  logic [WW-1:0]      w_q, w_d, w_eff;
  logic [N-1:0]       average_q, average_d;
  logic               average_valid_q, average_valid_d;
  logic [CW-1:0]      average_chan_q, average_chan_d;
  logic [C-1:0]       warm_q, warm_d;

  logic               flush;
  logic [FW-1:0]      win_size;
  logic [M_MAX-1:0]   cur_ptr;
  logic [FW-1:0]      cur_fill, new_fill;
  logic [SW-1:0]      cur_sum, new_sum, rnd_add, avg_full;
  logic [N-1:0]       oldest;

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
    w_eff    = (32'(bus.win_log2) > M_MAX) ? WW'(M_MAX) : bus.win_log2;
    w_d      = w_eff;
    flush    = bus.clear | (w_eff != w_q);
    win_size = FW'(1) << w_eff;
    wptr_d   = wptr_q;
    fill_d   = fill_q;
    sum_d    = sum_q;

    for (int c = 0; c < C; c++) begin
      if (flush) begin
        fill_d[c] = '0;
        sum_d[c]  = '0;
      end
      if (bus.clear) wptr_d[c] = '0;
    end

    // A coincident sample sees the flushed state and becomes the first sample of the new window.
    cur_ptr  = wptr_d[bus.sample_chan];
    cur_fill = fill_d[bus.sample_chan];
    cur_sum  = sum_d[bus.sample_chan];
    oldest   = (cur_fill >= win_size) ? mem_q[bus.sample_chan][cur_ptr - win_size[M_MAX-1:0]] : '0;
    new_sum  = cur_sum + SW'(bus.sample) - SW'(oldest);
    new_fill = (cur_fill == FW'(DEPTH)) ? cur_fill : cur_fill + FW'(1);

`ifdef MAVG_ROUND_EN
    rnd_add  = SW'(win_size >> 1);
`else
    rnd_add  = '0;
`endif
    avg_full = (new_sum + rnd_add) >> w_eff;

    average_d       = average_q;
    average_valid_d = 1'b0;
    average_chan_d  = average_chan_q;

    if (bus.sample_valid) begin
      wptr_d[bus.sample_chan] = cur_ptr + M_MAX'(1);
      fill_d[bus.sample_chan] = new_fill;
      sum_d[bus.sample_chan]  = new_sum;
      if (new_fill >= win_size) begin
        average_d       = avg_full[N-1:0];
        average_valid_d = 1'b1;
        average_chan_d  = bus.sample_chan;
      end
    end

    for (int c = 0; c < C; c++) warm_d[c] = (fill_d[c] >= win_size);
  end

  // NOTE: the sample buffer has no reset; fill counters gate every read, so stale entries never matter.
  always_ff @(posedge clk) begin
    if (bus.sample_valid) mem_q[bus.sample_chan][cur_ptr] <= bus.sample;
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_q             <= w_eff;
      wptr_q          <= '{default: '0};
      fill_q          <= '{default: '0};
      sum_q           <= '{default: '0};
      average_q       <= '0;
      average_valid_q <= 1'b0;
      average_chan_q  <= '0;
      warm_q          <= '0;
    end else begin
      w_q             <= w_d;
      wptr_q          <= wptr_d;
      fill_q          <= fill_d;
      sum_q           <= sum_d;
      average_q       <= average_d;
      average_valid_q <= average_valid_d;
      average_chan_q  <= average_chan_d;
      warm_q          <= warm_d;
    end
  end

  assign bus.average       = average_q;
  assign bus.average_valid = average_valid_q;
  assign bus.average_chan  = average_chan_q;
  assign bus.warm          = warm_q;
endmodule

// File: tb/tb_mavg_filter_mc.sv
// Directed self-checking bench for mavg_filter_mc: one task per scenario, inline comparisons.
module tb_mavg_filter_mc;
  localparam int N     = 16;
  localparam int M_MAX = 3;
  localparam int C     = 4;
  localparam int CW    = 2;
  localparam int WW    = 2;
`ifdef MAVG_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mavg_filter_mc_if #(.N(N), .M_MAX(M_MAX), .C(C)) bus ();

  mavg_filter_mc #(.N(N), .M_MAX(M_MAX), .C(C)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int exp_avg(input int sum, input int w);
    if (ROUND && w > 0) return (sum + (1 << (w - 1))) >> w;
    return sum >> w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int ch, input int val);
    bus.sample_valid = 1'b1;
    bus.sample_chan  = CW'(ch);
    bus.sample       = N'(val);
    tick();
    bus.sample_valid = 1'b0;
  endtask

  task automatic flush_to(input int w);
    bus.win_log2 = WW'(w);
    bus.clear    = 1'b1;
    tick();
    bus.clear    = 1'b0;
  endtask

  task automatic test_reset();
    bus.win_log2 = 2'd2;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (bus.average !== 16'd0) begin errors++; $display("FAIL reset_average: got %0d expected 0", bus.average); end
    checks++; if (bus.average_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.average_valid); end
    checks++; if (bus.average_chan !== 2'd0) begin errors++; $display("FAIL reset_chan: got %0d expected 0", bus.average_chan); end
    checks++; if (bus.warm !== 4'b0000) begin errors++; $display("FAIL reset_warm: got %b expected 0000", bus.warm); end
  endtask

  task automatic test_basic();
    int vals[4] = '{4, 8, 12, 16};
    for (int i = 0; i < 3; i++) begin
      send(0, vals[i]);
      checks++; if (bus.average_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid[%0d]: got %b expected 0", i, bus.average_valid); end
    end
    send(0, vals[3]);
    checks++; if (bus.average_valid !== 1'b1 || bus.average !== 16'(exp_avg(40, 2))) begin
      errors++; $display("FAIL basic_first_avg: got v=%b avg=%0d expected v=1 avg=%0d", bus.average_valid, bus.average, exp_avg(40, 2)); end
    checks++; if (bus.warm !== 4'b0001) begin errors++; $display("FAIL basic_warm: got %b expected 0001", bus.warm); end
    send(0, 20);
    checks++; if (bus.average_valid !== 1'b1 || bus.average !== 16'(exp_avg(56, 2))) begin
      errors++; $display("FAIL basic_slide_avg: got v=%b avg=%0d expected v=1 avg=%0d", bus.average_valid, bus.average, exp_avg(56, 2)); end
    tick();
    checks++; if (bus.average_valid !== 1'b0 || bus.average !== 16'(exp_avg(56, 2))) begin
      errors++; $display("FAIL basic_hold: got v=%b avg=%0d expected v=0 avg=%0d", bus.average_valid, bus.average, exp_avg(56, 2)); end
  endtask

  task automatic test_interleave();
    flush_to(2);
    checks++; if (bus.warm !== 4'b0000) begin errors++; $display("FAIL clear_warm: got %b expected 0000", bus.warm); end
    for (int i = 0; i < 3; i++) begin
      send(0, 100);
      send(1, 4);
      checks++; if (bus.average_valid !== 1'b0) begin errors++; $display("FAIL inter_early_valid[%0d]: got %b expected 0", i, bus.average_valid); end
    end
    send(0, 100);
    checks++; if (bus.average_valid !== 1'b1 || bus.average !== 16'd100 || bus.average_chan !== 2'd0) begin
      errors++; $display("FAIL inter_ch0: got v=%b avg=%0d ch=%0d expected v=1 avg=100 ch=0", bus.average_valid, bus.average, bus.average_chan); end
    send(1, 4);
    checks++; if (bus.average_valid !== 1'b1 || bus.average !== 16'd4 || bus.average_chan !== 2'd1) begin
      errors++; $display("FAIL inter_ch1: got v=%b avg=%0d ch=%0d expected v=1 avg=4 ch=1", bus.average_valid, bus.average, bus.average_chan); end
    checks++; if (bus.warm !== 4'b0011) begin errors++; $display("FAIL inter_warm: got %b expected 0011", bus.warm); end
  endtask

  task automatic test_w_change();
    flush_to(2);
    send(1, 10); send(1, 20); send(1, 30); send(1, 40);
    checks++; if (bus.average_valid !== 1'b1 || bus.average !== 16'd25) begin
      errors++; $display("FAIL wchg_warm_avg: got v=%b avg=%0d expected v=1 avg=25", bus.average_valid, bus.average); end
    bus.win_log2 = 2'd1;
    send(1, 50);
    checks++; if (bus.average_valid !== 1'b0 || bus.average !== 16'd25) begin
      errors++; $display("FAIL wchg_flush: got v=%b avg=%0d expected v=0 avg=25", bus.average_valid, bus.average); end
    checks++; if (bus.warm !== 4'b0000) begin errors++; $display("FAIL wchg_warm_cleared: got %b expected 0000", bus.warm); end
    send(1, 70);
    checks++; if (bus.average_valid !== 1'b1 || bus.average !== 16'(exp_avg(120, 1)) || bus.average_chan !== 2'd1) begin
      errors++; $display("FAIL wchg_refill: got v=%b avg=%0d ch=%0d expected v=1 avg=%0d ch=1", bus.average_valid, bus.average, bus.average_chan, exp_avg(120, 1)); end
    checks++; if (bus.warm !== 4'b0010) begin errors++; $display("FAIL wchg_warm_set: got %b expected 0010", bus.warm); end
  endtask

  task automatic test_clear_reset();
    flush_to(2);
    for (int i = 0; i < 4; i++) send(0, 8);
    checks++; if (bus.average_valid !== 1'b1 || bus.average !== 16'd8 || bus.warm !== 4'b0001) begin
      errors++; $display("FAIL clr_prefill: got v=%b avg=%0d warm=%b expected v=1 avg=8 warm=0001", bus.average_valid, bus.average, bus.warm); end
    flush_to(2);
    checks++; if (bus.warm !== 4'b0000 || bus.average_valid !== 1'b0) begin
      errors++; $display("FAIL clr_midstream: got warm=%b v=%b expected warm=0000 v=0", bus.warm, bus.average_valid); end
    send(0, 5);
    send(0, 5);
    rst = 1'b1;
    send(0, 9);
    rst = 1'b0;
    checks++; if (bus.average_valid !== 1'b0 || bus.warm !== 4'b0000 || bus.average !== 16'd0) begin
      errors++; $display("FAIL rst_midstream: got v=%b warm=%b avg=%0d expected v=0 warm=0000 avg=0", bus.average_valid, bus.warm, bus.average); end
    tick();
    checks++; if (bus.average_valid !== 1'b0) begin errors++; $display("FAIL rst_after: got v=%b expected 0", bus.average_valid); end
    for (int i = 0; i < 3; i++) begin
      send(0, 4);
      checks++; if (bus.average_valid !== 1'b0) begin errors++; $display("FAIL rst_refill_early[%0d]: got v=%b expected 0", i, bus.average_valid); end
    end
    send(0, 4);
    checks++; if (bus.average_valid !== 1'b1 || bus.average !== 16'd4) begin
      errors++; $display("FAIL rst_refill: got v=%b avg=%0d expected v=1 avg=4", bus.average_valid, bus.average); end
  endtask

  task automatic test_passthrough();
    flush_to(0);
    send(0, 123);
    checks++; if (bus.average_valid !== 1'b1 || bus.average !== 16'd123 || bus.average_chan !== 2'd0) begin
      errors++; $display("FAIL pass_a: got v=%b avg=%0d ch=%0d expected v=1 avg=123 ch=0", bus.average_valid, bus.average, bus.average_chan); end
    send(2, 7);
    checks++; if (bus.average_valid !== 1'b1 || bus.average !== 16'd7 || bus.average_chan !== 2'd2) begin
      errors++; $display("FAIL pass_b: got v=%b avg=%0d ch=%0d expected v=1 avg=7 ch=2", bus.average_valid, bus.average, bus.average_chan); end
  endtask

  task automatic test_round();
    flush_to(1);
    send(3, 3);
    checks++; if (bus.average_valid !== 1'b0) begin errors++; $display("FAIL round_early: got v=%b expected 0", bus.average_valid); end
    send(3, 4);
    checks++; if (bus.average_valid !== 1'b1 || bus.average !== 16'(ROUND ? 4 : 3)) begin
      errors++; $display("FAIL round_avg: got v=%b avg=%0d expected v=1 avg=%0d", bus.average_valid, bus.average, ROUND ? 4 : 3); end
  endtask

  task automatic test_full_scale();
    flush_to(3);
    for (int i = 0; i < 7; i++) send(2, 65535);
    checks++; if (bus.average_valid !== 1'b0) begin errors++; $display("FAIL full_early: got v=%b expected 0", bus.average_valid); end
    send(2, 65535);
    checks++; if (bus.average_valid !== 1'b1 || bus.average !== 16'd65535 || bus.average_chan !== 2'd2) begin
      errors++; $display("FAIL full_max: got v=%b avg=%0d ch=%0d expected v=1 avg=65535 ch=2", bus.average_valid, bus.average, bus.average_chan); end
    checks++; if (bus.warm !== 4'b0100) begin errors++; $display("FAIL full_warm: got %b expected 0100", bus.warm); end
    for (int k = 1; k <= 8; k++) begin
      send(2, 0);
      checks++; if (bus.average_valid !== 1'b1 || bus.average !== 16'(exp_avg((8 - k) * 65535, 3))) begin
        errors++; $display("FAIL full_decay[%0d]: got v=%b avg=%0d expected v=1 avg=%0d", k, bus.average_valid, bus.average, exp_avg((8 - k) * 65535, 3)); end
    end
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    rst              = 1'b0;
    bus.sample       = '0;
    bus.sample_valid = 1'b0;
    bus.sample_chan  = '0;
    bus.win_log2     = 2'd2;
    bus.clear        = 1'b0;

    test_reset();
    test_basic();
    test_interleave();
    test_w_change();
    test_clear_reset();
    test_passthrough();
    test_round();
    test_full_scale();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
